// File: rtl/tx_payload_enq_ctrl.sv
// TX payload enqueue controller: reads a flow's head/tail, reserves ring space, advances tail.
// Optional statistics counters are built when TX_ENQ_STATS_EN is defined.
module tx_payload_enq_ctrl #(
  parameter int PTR_W    = 4,
  parameter int FLOWID_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_req_val,
  output logic                enq_req_rdy,
  input  logic [FLOWID_W-1:0] enq_req_flowid,
  input  logic [PTR_W:0]      enq_req_len,
  output logic                enq_resp_val,
  input  logic                enq_resp_rdy,
  output logic [FLOWID_W-1:0] enq_resp_flowid,
  output logic                enq_resp_ok,
  output logic [PTR_W-1:0]    enq_resp_addr,
  output logic                head_rd_req_val,
  input  logic                head_rd_req_rdy,
  output logic [FLOWID_W-1:0] head_rd_req_flowid,
  input  logic                head_rd_resp_val,
  output logic                head_rd_resp_rdy,
  input  logic [PTR_W:0]      head_rd_resp_data,
  output logic                tail_rd_req_val,
  input  logic                tail_rd_req_rdy,
  output logic [FLOWID_W-1:0] tail_rd_req_flowid,
  input  logic                tail_rd_resp_val,
  output logic                tail_rd_resp_rdy,
  input  logic [PTR_W:0]      tail_rd_resp_data,
  output logic                tail_wr_req_val,
  input  logic                tail_wr_req_rdy,
  output logic [FLOWID_W-1:0] tail_wr_req_flowid,
  output logic [PTR_W:0]      tail_wr_req_data,
  output logic [31:0]         stat_accept_cnt,
  output logic [31:0]         stat_reject_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_TAIL, S_RESP} state_t;

  localparam logic [PTR_W:0] CAP = {1'b1, {PTR_W{1'b0}}};

  state_t                state_q, state_d;
  logic [FLOWID_W-1:0]   flowid_q, flowid_d;
  logic [PTR_W:0]        len_q, len_d;
  logic [PTR_W:0]        head_q, head_d;
  logic [PTR_W:0]        tail_q, tail_d;
  logic [PTR_W:0]        wr_data_q, wr_data_d;
  logic                  head_sent_q, head_sent_d;
  logic                  tail_sent_q, tail_sent_d;
  logic                  head_cap_q, head_cap_d;
  logic                  tail_cap_q, tail_cap_d;
  logic                  enq_req_rdy_q, enq_req_rdy_d;
  logic                  head_req_val_q, head_req_val_d;
  logic                  tail_req_val_q, tail_req_val_d;
  logic                  head_resp_rdy_q, head_resp_rdy_d;
  logic                  tail_resp_rdy_q, tail_resp_rdy_d;
  logic                  wr_val_q, wr_val_d;
  logic                  resp_val_q, resp_val_d;
  logic                  resp_ok_q, resp_ok_d;
  logic [PTR_W-1:0]      resp_addr_q, resp_addr_d;

  logic                  enq_req_fire, enq_resp_fire, wr_fire;
  logic                  head_req_fire, tail_req_fire, head_resp_fire, tail_resp_fire;
  logic [PTR_W:0]        head_eff, tail_eff, used, free;
  logic                  fits;

  assign enq_req_fire   = enq_req_val & enq_req_rdy_q;
  assign enq_resp_fire  = resp_val_q & enq_resp_rdy;
  assign wr_fire        = wr_val_q & tail_wr_req_rdy;
  assign head_req_fire  = head_req_val_q & head_rd_req_rdy;
  assign tail_req_fire  = tail_req_val_q & tail_rd_req_rdy;
  assign head_resp_fire = head_rd_resp_val & head_resp_rdy_q;
  assign tail_resp_fire = tail_rd_resp_val & tail_resp_rdy_q;

  // Decide on the response being captured this cycle if it has not been latched yet.
  assign head_eff = head_cap_q ? head_q : head_rd_resp_data;
  assign tail_eff = tail_cap_q ? tail_q : tail_rd_resp_data;
  assign used     = tail_eff - head_eff;
  assign free     = CAP - used;
  assign fits     = (len_q != '0) && (len_q <= free);

  always_comb begin
    state_d     = state_q;
    flowid_d    = flowid_q;
    len_d       = len_q;
    head_d      = head_q;
    tail_d      = tail_q;
    wr_data_d   = wr_data_q;
    head_sent_d = head_sent_q;
    tail_sent_d = tail_sent_q;
    head_cap_d  = head_cap_q;
    tail_cap_d  = tail_cap_q;
    resp_ok_d   = resp_ok_q;
    resp_addr_d = resp_addr_q;

    if (state_q == S_RD_REQ || state_q == S_RD_WAIT) begin
      if (head_resp_fire) begin
        head_d     = head_rd_resp_data;
        head_cap_d = 1'b1;
      end
      if (tail_resp_fire) begin
        tail_d     = tail_rd_resp_data;
        tail_cap_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enq_req_fire) begin
          flowid_d    = enq_req_flowid;
          len_d       = enq_req_len;
          head_sent_d = 1'b0;
          tail_sent_d = 1'b0;
          head_cap_d  = 1'b0;
          tail_cap_d  = 1'b0;
          state_d     = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (head_req_fire) head_sent_d = 1'b1;
        if (tail_req_fire) tail_sent_d = 1'b1;
        if (head_sent_d && tail_sent_d) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (head_cap_d && tail_cap_d) begin
          resp_ok_d   = fits;
          resp_addr_d = tail_eff[PTR_W-1:0];
          wr_data_d   = tail_eff + len_q;
          state_d     = fits ? S_WR_TAIL : S_RESP;
        end
      end
      S_WR_TAIL: begin
        if (wr_fire) state_d = S_RESP;
      end
      S_RESP: begin
        if (enq_resp_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered from the next state so none depends on a same-cycle rdy.
    enq_req_rdy_d   = (state_d == S_IDLE);
    head_req_val_d  = (state_d == S_RD_REQ) && !head_sent_d;
    tail_req_val_d  = (state_d == S_RD_REQ) && !tail_sent_d;
    head_resp_rdy_d = (state_d == S_RD_REQ || state_d == S_RD_WAIT) && !head_cap_d;
    tail_resp_rdy_d = (state_d == S_RD_REQ || state_d == S_RD_WAIT) && !tail_cap_d;
    wr_val_d        = (state_d == S_WR_TAIL);
    resp_val_d      = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      flowid_q        <= '0;
      len_q           <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      wr_data_q       <= '0;
      head_sent_q     <= 1'b0;
      tail_sent_q     <= 1'b0;
      head_cap_q      <= 1'b0;
      tail_cap_q      <= 1'b0;
      enq_req_rdy_q   <= 1'b0;
      head_req_val_q  <= 1'b0;
      tail_req_val_q  <= 1'b0;
      head_resp_rdy_q <= 1'b0;
      tail_resp_rdy_q <= 1'b0;
      wr_val_q        <= 1'b0;
      resp_val_q      <= 1'b0;
      resp_ok_q       <= 1'b0;
      resp_addr_q     <= '0;
    end else begin
      state_q         <= state_d;
      flowid_q        <= flowid_d;
      len_q           <= len_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      wr_data_q       <= wr_data_d;
      head_sent_q     <= head_sent_d;
      tail_sent_q     <= tail_sent_d;
      head_cap_q      <= head_cap_d;
      tail_cap_q      <= tail_cap_d;
      enq_req_rdy_q   <= enq_req_rdy_d;
      head_req_val_q  <= head_req_val_d;
      tail_req_val_q  <= tail_req_val_d;
      head_resp_rdy_q <= head_resp_rdy_d;
      tail_resp_rdy_q <= tail_resp_rdy_d;
      wr_val_q        <= wr_val_d;
      resp_val_q      <= resp_val_d;
      resp_ok_q       <= resp_ok_d;
      resp_addr_q     <= resp_addr_d;
    end
  end

  assign enq_req_rdy        = enq_req_rdy_q;
  assign enq_resp_val       = resp_val_q;
  assign enq_resp_flowid    = resp_val_q ? flowid_q : '0;
  assign enq_resp_ok        = resp_ok_q;
  assign enq_resp_addr      = resp_addr_q;
  assign head_rd_req_val    = head_req_val_q;
  assign head_rd_req_flowid = flowid_q;
  assign head_rd_resp_rdy   = head_resp_rdy_q;
  assign tail_rd_req_val    = tail_req_val_q;
  assign tail_rd_req_flowid = flowid_q;
  assign tail_rd_resp_rdy   = tail_resp_rdy_q;
  assign tail_wr_req_val    = wr_val_q;
  assign tail_wr_req_flowid = flowid_q;
  assign tail_wr_req_data   = wr_data_q;

`ifdef TX_ENQ_STATS_EN
  logic [31:0] acc_q, acc_d, rej_q, rej_d;

  always_comb begin
    acc_d = acc_q;
    rej_d = rej_q;
    if (enq_resp_fire) begin
      if (resp_ok_q) begin
        if (acc_q != 32'hFFFF_FFFF) acc_d = acc_q + 32'd1;
      end else begin
        if (rej_q != 32'hFFFF_FFFF) rej_d = rej_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      rej_q <= '0;
    end else begin
      acc_q <= acc_d;
      rej_q <= rej_d;
    end
  end

  assign stat_accept_cnt = acc_q;
  assign stat_reject_cnt = rej_q;
`else
  assign stat_accept_cnt = 32'd0;
  assign stat_reject_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_tx_payload_enq_ctrl.sv
// Directed bench for tx_payload_enq_ctrl (PTR_W=4) with a behavioural head/tail pointer store.
`timescale 1ns/1ps
module tb_tx_payload_enq_ctrl;
  localparam int PTR_W    = 4;
  localparam int FLOWID_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                enq_req_val, enq_req_rdy;
  logic [FLOWID_W-1:0] enq_req_flowid;
  logic [PTR_W:0]      enq_req_len;
  logic                enq_resp_val, enq_resp_rdy;
  logic [FLOWID_W-1:0] enq_resp_flowid;
  logic                enq_resp_ok;
  logic [PTR_W-1:0]    enq_resp_addr;
  logic                head_rd_req_val, head_rd_req_rdy;
  logic [FLOWID_W-1:0] head_rd_req_flowid;
  logic                head_rd_resp_val, head_rd_resp_rdy;
  logic [PTR_W:0]      head_rd_resp_data;
  logic                tail_rd_req_val, tail_rd_req_rdy;
  logic [FLOWID_W-1:0] tail_rd_req_flowid;
  logic                tail_rd_resp_val, tail_rd_resp_rdy;
  logic [PTR_W:0]      tail_rd_resp_data;
  logic                tail_wr_req_val, tail_wr_req_rdy;
  logic [FLOWID_W-1:0] tail_wr_req_flowid;
  logic [PTR_W:0]      tail_wr_req_data;
  logic [31:0]         stat_accept_cnt, stat_reject_cnt;

  tx_payload_enq_ctrl #(.PTR_W(PTR_W), .FLOWID_W(FLOWID_W)) dut (
    .clk(clk), .rst(rst),
    .enq_req_val(enq_req_val), .enq_req_rdy(enq_req_rdy),
    .enq_req_flowid(enq_req_flowid), .enq_req_len(enq_req_len),
    .enq_resp_val(enq_resp_val), .enq_resp_rdy(enq_resp_rdy),
    .enq_resp_flowid(enq_resp_flowid), .enq_resp_ok(enq_resp_ok), .enq_resp_addr(enq_resp_addr),
    .head_rd_req_val(head_rd_req_val), .head_rd_req_rdy(head_rd_req_rdy),
    .head_rd_req_flowid(head_rd_req_flowid),
    .head_rd_resp_val(head_rd_resp_val), .head_rd_resp_rdy(head_rd_resp_rdy),
    .head_rd_resp_data(head_rd_resp_data),
    .tail_rd_req_val(tail_rd_req_val), .tail_rd_req_rdy(tail_rd_req_rdy),
    .tail_rd_req_flowid(tail_rd_req_flowid),
    .tail_rd_resp_val(tail_rd_resp_val), .tail_rd_resp_rdy(tail_rd_resp_rdy),
    .tail_rd_resp_data(tail_rd_resp_data),
    .tail_wr_req_val(tail_wr_req_val), .tail_wr_req_rdy(tail_wr_req_rdy),
    .tail_wr_req_flowid(tail_wr_req_flowid), .tail_wr_req_data(tail_wr_req_data),
    .stat_accept_cnt(stat_accept_cnt), .stat_reject_cnt(stat_reject_cnt)
  );

  logic [PTR_W:0] head_mem [0:255];
  logic [PTR_W:0] tail_mem [0:255];
  int vec_cnt = 0, miss_cnt = 0;
  int head_req_cnt = 0, tail_req_cnt = 0, wr_cnt = 0;
  int head_delay = 0, tail_delay = 0;
  logic [PTR_W:0]      wr_data_seen = '0;
  logic [FLOWID_W-1:0] wr_flow_seen = '0;

  // Pointer store read ports: answer each request after a programmable delay.
  initial begin : head_port
    bit req_f, resp_f;
    int wait_n;
    head_rd_resp_val = 1'b0; head_rd_resp_data = '0; wait_n = -1;
    forever begin
      @(negedge clk);
      req_f  = head_rd_req_val && head_rd_req_rdy;
      resp_f = head_rd_resp_val && head_rd_resp_rdy;
      @(posedge clk); #1;
      if (rst) begin
        head_rd_resp_val = 1'b0; wait_n = -1;
      end else begin
        if (resp_f) head_rd_resp_val = 1'b0;
        if (req_f) begin
          head_req_cnt++;
          head_rd_resp_data = head_mem[head_rd_req_flowid];
          wait_n = head_delay;
        end
        if (wait_n == 0) head_rd_resp_val = 1'b1;
        if (wait_n >= 0) wait_n--;
      end
    end
  end

  initial begin : tail_port
    bit req_f, resp_f;
    int wait_n;
    tail_rd_resp_val = 1'b0; tail_rd_resp_data = '0; wait_n = -1;
    forever begin
      @(negedge clk);
      req_f  = tail_rd_req_val && tail_rd_req_rdy;
      resp_f = tail_rd_resp_val && tail_rd_resp_rdy;
      @(posedge clk); #1;
      if (rst) begin
        tail_rd_resp_val = 1'b0; wait_n = -1;
      end else begin
        if (resp_f) tail_rd_resp_val = 1'b0;
        if (req_f) begin
          tail_req_cnt++;
          tail_rd_resp_data = tail_mem[tail_rd_req_flowid];
          wait_n = tail_delay;
        end
        if (wait_n == 0) tail_rd_resp_val = 1'b1;
        if (wait_n >= 0) wait_n--;
      end
    end
  end

  initial begin : tail_write_port
    forever begin
      @(negedge clk);
      if (!rst && tail_wr_req_val && tail_wr_req_rdy) begin
        wr_cnt++;
        wr_data_seen = tail_wr_req_data;
        wr_flow_seen = tail_wr_req_flowid;
        tail_mem[tail_wr_req_flowid] = tail_wr_req_data;
      end
    end
  end

  typedef struct {
    logic [7:0] flow;
    logic [4:0] head;
    logic [4:0] tail;
    logic [4:0] len;
    logic       ok;
    logic [3:0] addr;
    logic [4:0] wdata;
    int         lat;
  } vec_t;

  vec_t tbl [9];
  vec_t post [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] f, input logic [4:0] l);
    int n;
    n = 0;
    @(posedge clk); #1;
    enq_req_val = 1'b1; enq_req_flowid = f; enq_req_len = l;
    forever begin
      @(negedge clk); n++;
      if (enq_req_rdy) break;
      if (n > 50) begin check("req_accept_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
    enq_req_val = 1'b0;
  endtask

  task automatic wait_resp(output logic ok, output logic [3:0] addr,
                           output logic [7:0] fl, output int lat);
    lat = 0; ok = 1'b0; addr = '0; fl = '0;
    forever begin
      @(negedge clk); lat++;
      if (enq_resp_val) break;
      if (lat > 60) begin check("resp_timeout", 32'd0, 32'd1); lat = -1; return; end
    end
    ok = enq_resp_ok; addr = enq_resp_addr; fl = enq_resp_flowid;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int h0, t0, w0, lat;
    logic ok;
    logic [3:0] addr;
    logic [7:0] fl;
    head_mem[v.flow] = v.head;
    tail_mem[v.flow] = v.tail;
    h0 = head_req_cnt; t0 = tail_req_cnt; w0 = wr_cnt;
    send_req(v.flow, v.len);
    wait_resp(ok, addr, fl, lat);
    check({tag, "_ok"},     32'(ok),   32'(v.ok));
    check({tag, "_addr"},   32'(addr), 32'(v.addr));
    check({tag, "_flowid"}, 32'(fl),   32'(v.flow));
    check({tag, "_lat"},    32'(lat),  32'(v.lat));
    check({tag, "_wr_cnt"}, 32'(wr_cnt - w0), v.ok ? 32'd1 : 32'd0);
    if (v.ok) begin
      check({tag, "_wr_data"}, 32'(wr_data_seen), 32'(v.wdata));
      check({tag, "_wr_flow"}, 32'(wr_flow_seen), 32'(v.flow));
    end
    check({tag, "_head_rd_once"}, 32'(head_req_cnt - h0), 32'd1);
    check({tag, "_tail_rd_once"}, 32'(tail_req_cnt - t0), 32'd1);
    @(negedge clk);
    check({tag, "_idle_rdy"}, 32'(enq_req_rdy), 32'd1);
    $display("vec %s flow=%0h head=%0h tail=%0h len=%0d -> ok=%0b addr=%0h lat=%0d",
             tag, v.flow, v.head, v.tail, v.len, ok, addr, lat);
  endtask

  initial begin : main
    int n, h0, t0, w0, lat;
    logic ok;
    logic [3:0] addr;
    logic [7:0] fl;
    logic [31:0] exp_acc, exp_rej;

    //          flow   head   tail   len    ok    addr   wdata  lat
    tbl[0] = '{8'd3, 5'h00, 5'h00, 5'd16, 1'b1, 4'h0, 5'h10, 4};
    tbl[1] = '{8'd1, 5'h10, 5'h1E, 5'd3,  1'b0, 4'hE, 5'h00, 3};
    tbl[2] = '{8'd1, 5'h10, 5'h1E, 5'd2,  1'b1, 4'hE, 5'h00, 4};
    tbl[3] = '{8'd2, 5'h00, 5'h00, 5'd0,  1'b0, 4'h0, 5'h00, 3};
    tbl[4] = '{8'd4, 5'h03, 5'h13, 5'd1,  1'b0, 4'h3, 5'h00, 3};
    tbl[5] = '{8'd5, 5'h07, 5'h0A, 5'd13, 1'b1, 4'hA, 5'h17, 4};
    tbl[6] = '{8'd5, 5'h07, 5'h0A, 5'd14, 1'b0, 4'hA, 5'h00, 3};
    tbl[7] = '{8'd6, 5'h1C, 5'h0C, 5'd16, 1'b0, 4'hC, 5'h00, 3};
    tbl[8] = '{8'd7, 5'h18, 5'h1F, 5'd9,  1'b1, 4'hF, 5'h08, 4};
    post[0] = '{8'd9,  5'h00, 5'h00, 5'd4,  1'b1, 4'h0, 5'h04, 4};
    post[1] = '{8'd10, 5'h05, 5'h08, 5'd13, 1'b1, 4'h8, 5'h15, 4};
    post[2] = '{8'd11, 5'h00, 5'h10, 5'd1,  1'b0, 4'h0, 5'h00, 3};
    post[3] = '{8'd12, 5'h1F, 5'h1F, 5'd16, 1'b1, 4'hF, 5'h0F, 4};
    post[4] = '{8'd13, 5'h02, 5'h0C, 5'd0,  1'b0, 4'hC, 5'h00, 3};

    enq_req_val = 1'b0; enq_req_flowid = '0; enq_req_len = '0; enq_resp_rdy = 1'b1;
    head_rd_req_rdy = 1'b1; tail_rd_req_rdy = 1'b1; tail_wr_req_rdy = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_rdy",   32'(enq_req_rdy), 32'd0);
    check("rst_vals",      32'({enq_resp_val, head_rd_req_val, tail_rd_req_val, tail_wr_req_val}), 32'd0);
    check("rst_resp_flds", 32'({enq_resp_ok, enq_resp_addr, enq_resp_flowid}), 32'd0);
    check("rst_stats",     stat_accept_cnt | stat_reject_cnt, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_req_rdy", 32'(enq_req_rdy), 32'd1);
    $display("reset checks done");

    for (int i = 0; i < 9; i++) run_vec($sformatf("t%0d", i), tbl[i]);

`ifdef TX_ENQ_STATS_EN
    exp_acc = 32'd4; exp_rej = 32'd5;
`else
    exp_acc = 32'd0; exp_rej = 32'd0;
`endif
    check("tbl_stat_acc", stat_accept_cnt, exp_acc);
    check("tbl_stat_rej", stat_reject_cnt, exp_rej);

    // Tail read stalled, then tail response returns before the delayed head response.
    head_mem[8] = 5'h02; tail_mem[8] = 5'h05;
    h0 = head_req_cnt; t0 = tail_req_cnt; w0 = wr_cnt;
    tail_rd_req_rdy = 1'b0; head_delay = 8;
    send_req(8'd8, 5'd4);
    repeat (5) @(posedge clk);
    #1 tail_rd_req_rdy = 1'b1;
    wait_resp(ok, addr, fl, lat);
    head_delay = 0;
    check("stall_ok",      32'(ok),   32'd1);
    check("stall_addr",    32'(addr), 32'h5);
    check("stall_wr_data", 32'(wr_data_seen), 32'h09);
    check("stall_wr_cnt",  32'(wr_cnt - w0), 32'd1);
    check("stall_head_rd", 32'(head_req_cnt - h0), 32'd1);
    check("stall_tail_rd", 32'(tail_req_cnt - t0), 32'd1);
    $display("stall seq flow=8 -> ok=%0b addr=%0h lat=%0d", ok, addr, lat);

    // Reset while the tail write is being held off.
    head_mem[9] = 5'h00; tail_mem[9] = 5'h00;
    w0 = wr_cnt;
    tail_wr_req_rdy = 1'b0;
    send_req(8'd9, 5'd4);
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (tail_wr_req_val) break;
      if (n > 30) begin check("wr_tail_timeout", 32'd0, 32'd1); break; end
    end
    rst = 1'b1;
    #1;
    check("mid_rst_wr_val",   32'(tail_wr_req_val), 32'd0);
    check("mid_rst_resp_val", 32'(enq_resp_val),    32'd0);
    check("mid_rst_req_rdy",  32'(enq_req_rdy),     32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; tail_wr_req_rdy = 1'b1;
    repeat (3) @(negedge clk) check("after_rst_no_resp", 32'(enq_resp_val), 32'd0);
    check("after_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("after_rst_stats", stat_accept_cnt | stat_reject_cnt, 32'd0);
    $display("mid-transaction reset seq done");

    for (int i = 0; i < 5; i++) run_vec($sformatf("p%0d", i), post[i]);

`ifdef TX_ENQ_STATS_EN
    exp_acc = 32'd3; exp_rej = 32'd2;
`else
    exp_acc = 32'd0; exp_rej = 32'd0;
`endif
    check("stat_acc", stat_accept_cnt, exp_acc);
    check("stat_rej", stat_reject_cnt, exp_rej);
    $display("stats acc=%0d rej=%0d", stat_accept_cnt, stat_reject_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
